// File: rtl/sys_ctrl_burst.sv
// UART command-frame controller: decodes RX bytes into register-file reads/writes
// (single and burst), ALU runs and multi-byte transmit, with a mid-frame idle timeout.
module sys_ctrl_burst #(
  parameter int WIDTH         = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FUN_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  output logic                     ALU_En,
  output logic [FUN_WIDTH-1:0]     ALU_Fun,
  output logic                     CLK_En,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         RdData,
  input  logic                     RdData_Valid,
  output logic [WIDTH-1:0]         TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     Busy,
  output logic                     FRAME_ERR,
  output logic [3:0]               fsm_state
);

  localparam int NB    = (ALU_OUT_WIDTH + WIDTH - 1) / WIDTH;
  localparam int RES_W = NB * WIDTH;
  localparam int NBW   = $clog2(NB + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] CMD_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] CMD_FUN = WIDTH'(8'hDD);
  localparam logic [WIDTH-1:0] CMD_BWR = WIDTH'(8'hEE);
  localparam logic [WIDTH-1:0] CMD_BRD = WIDTH'(8'hFF);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT,
    BURST_ADDR, BURST_CNT, BURST_WR, BURST_RD, TX_SEND, TX_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic [RES_W-1:0]        res_q, res_d;
  logic [NBW-1:0]          nb_left_q, nb_left_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    busy_seen_q, busy_seen_d;
  logic                    burst_wr_q, burst_wr_d;
  logic                    first_q, first_d;
  logic                    rd_burst_q, rd_burst_d;
  logic [ADDR_WIDTH-1:0]   address_d;
  logic [WIDTH-1:0]        wr_data_d, tx_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;
  logic                    alu_en_d, clk_en_d, wr_en_d, rd_en_d, tx_vld_d, err_d;
  logic                    rx_state, timed_out;

  assign fsm_state = state_q;
  assign rx_state  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN,
                                     BURST_ADDR, BURST_CNT, BURST_WR};
  assign timed_out = rx_state && (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    nb_left_d   = nb_left_q;
    busy_seen_d = busy_seen_q;
    burst_wr_d  = burst_wr_q;
    first_d     = first_q;
    rd_burst_d  = rd_burst_q;
    address_d   = Address;
    wr_data_d   = WrData;
    tx_data_d   = TX_P_DATA;
    alu_fun_d   = ALU_Fun;
    alu_en_d    = 1'b0;
    clk_en_d    = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_vld_d    = 1'b0;
    err_d       = 1'b0;
    timer_d     = '0;
    if (rx_state && !RX_D_VLD) timer_d = timer_q + 1'b1;

    // Expiry takes priority over a byte arriving in the same cycle.
    if (timed_out) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (RX_D_VLD) begin
          burst_wr_d = (RX_P_DATA == CMD_BWR);
          if (RX_P_DATA == CMD_WR)                             state_d = WR_ADDR;
          else if (RX_P_DATA == CMD_RD)                        state_d = RD_ADDR;
          else if (RX_P_DATA == CMD_ALU)                       state_d = ALU_A;
          else if (RX_P_DATA == CMD_FUN)                       state_d = ALU_FUN;
          else if (RX_P_DATA == CMD_BWR || RX_P_DATA == CMD_BRD) state_d = BURST_ADDR;
          else err_d = 1'b1;
        end
        WR_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          address_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d    = 1'b1;
          rd_burst_d = 1'b0;
          state_d    = RD_WAIT;
        end
        RD_WAIT, BURST_RD: if (RdData_Valid) begin
          res_d            = '0;
          res_d[WIDTH-1:0] = RdData;
          nb_left_d        = NBW'(1);
          state_d          = TX_SEND;
        end
        ALU_A, ALU_B: if (RX_D_VLD) begin
          address_d = (state_q == ALU_A) ? '0 : ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = (state_q == ALU_A) ? ALU_B : ALU_FUN;
        end
        ALU_FUN: if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
        ALU_WAIT: begin
          // Gate stays open through the cycle after OUT_Valid.
          clk_en_d = 1'b1;
          if (OUT_Valid) begin
            res_d                    = '0;
            res_d[ALU_OUT_WIDTH-1:0] = ALU_OUT;
            nb_left_d                = NBW'(NB);
            rd_burst_d               = 1'b0;
            state_d                  = TX_SEND;
          end
        end
        BURST_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = BURST_CNT;
        end
        BURST_CNT: if (RX_D_VLD) begin
          if (RX_P_DATA == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (burst_wr_q) begin
            cnt_d   = RX_P_DATA;
            first_d = 1'b1;
            state_d = BURST_WR;
          end else begin
            cnt_d      = RX_P_DATA - 1'b1;
            rd_en_d    = 1'b1;
            rd_burst_d = 1'b1;
            state_d    = BURST_RD;
          end
        end
        BURST_WR: if (RX_D_VLD) begin
          if (!first_q) address_d = Address + 1'b1;
          first_d   = 1'b0;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == WIDTH'(1)) state_d = IDLE;
        end
        // Transmit handshake: a byte is offered (TX_D_VLD pulse) only while Busy is low;
        // it is complete once Busy has been seen high and then low again.
        TX_SEND: if (!Busy) begin
          tx_data_d   = res_q[WIDTH-1:0];
          tx_vld_d    = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = TX_WAIT;
        end
        TX_WAIT: begin
          if (Busy) begin
            busy_seen_d = 1'b1;
          end else if (busy_seen_q) begin
            busy_seen_d = 1'b0;
            res_d       = res_q >> WIDTH;
            if (nb_left_q > NBW'(1)) begin
              nb_left_d = nb_left_q - 1'b1;
              state_d   = TX_SEND;
            end else if (rd_burst_q && cnt_q != '0) begin
              address_d = Address + 1'b1;
              rd_en_d   = 1'b1;
              cnt_d     = cnt_q - 1'b1;
              state_d   = BURST_RD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (RX_D_VLD && (state_q inside {RD_WAIT, ALU_WAIT, BURST_RD, TX_SEND, TX_WAIT}))
      err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_q       <= '0;
      nb_left_q   <= '0;
      timer_q     <= '0;
      busy_seen_q <= 1'b0;
      burst_wr_q  <= 1'b0;
      first_q     <= 1'b0;
      rd_burst_q  <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      TX_P_DATA   <= '0;
      ALU_Fun     <= '0;
      ALU_En      <= 1'b0;
      CLK_En      <= 1'b0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      TX_D_VLD    <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      nb_left_q   <= nb_left_d;
      timer_q     <= timer_d;
      busy_seen_q <= busy_seen_d;
      burst_wr_q  <= burst_wr_d;
      first_q     <= first_d;
      rd_burst_q  <= rd_burst_d;
      Address     <= address_d;
      WrData      <= wr_data_d;
      TX_P_DATA   <= tx_data_d;
      ALU_Fun     <= alu_fun_d;
      ALU_En      <= alu_en_d;
      CLK_En      <= clk_en_d;
      WrEn        <= wr_en_d;
      RdEn        <= rd_en_d;
      TX_D_VLD    <= tx_vld_d;
      FRAME_ERR   <= err_d;
    end
  end

endmodule
